// File: rtl/mem_ctrl_pkg.sv
// Shared CPU defines: EX opcodes, memory size codes and
// memory controller state encodings.
package mem_ctrl_pkg;

    typedef enum logic [3:0] {
        EX_ADD, EX_SUB, EX_AND, EX_OR,
        EX_XOR, EX_SLL, EX_SRL, EX_SRA,
        EX_SLT, EX_SLTU, EX_LD, EX_ST,
        EX_BR, EX_JMP
    } ex_op_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // The reserved code 3 is served as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store
// requests onto an 8-bit synchronous RAM port.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic              jump_flag,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    mc_state_t         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nb_q, nb_d;
    logic              we_q, we_d;
    logic              fetch_q, fetch_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic        abort;
    logic        last;
    logic        adv;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx;
    logic [31:0] asm_w;

    assign abort  = fetch_q & jump_flag;
    assign last   = we_q ? (cnt_q == nb_q - 3'd1)
                         : (cnt_q == nb_q);
    assign adv    = (cnt_q + 3'd1) < nb_q;
    assign rd_idx = cnt_q[1:0] - 2'd1;
    assign wr_idx = cnt_q[1:0] + 2'd1;

    // Byte k arrives one cycle after its address, i.e. while cnt = k+1.
    always_comb begin
        asm_w = buf_q;
        asm_w[{rd_idx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nb_q        <= '0;
            we_q        <= 1'b0;
            fetch_q     <= 1'b0;
            wdata_q     <= '0;
            buf_q       <= '0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nb_q        <= nb_d;
            we_q        <= we_d;
            fetch_q     <= fetch_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req || (if_req && !jump_flag))
                    state_d = BUSY;
            end
            BUSY: begin
                if (abort)
                    state_d = IDLE;
                else if (last)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!rdy)
            state_d = state_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        nb_d        = nb_q;
        we_d        = we_q;
        fetch_d     = fetch_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if (rdy) begin
            ram_wr_d   = 1'b0;
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        cnt_d      = '0;
                        nb_d       = size_bytes(mem_len);
                        we_d       = mem_we;
                        fetch_d    = 1'b0;
                        wdata_d    = mem_wdata;
                        buf_d      = '0;
                        ram_a_d    = mem_addr;
                        ram_dout_d = mem_wdata[7:0];
                        ram_wr_d   = mem_we;
                    end else if (if_req && !jump_flag) begin
                        cnt_d      = '0;
                        nb_d       = 3'd4;
                        we_d       = 1'b0;
                        fetch_d    = 1'b1;
                        wdata_d    = '0;
                        buf_d      = '0;
                        ram_a_d    = if_addr;
                        ram_dout_d = '0;
                    end
                end
                BUSY: begin
                    if (!abort) begin
                        if (!we_q && cnt_q != 3'd0)
                            buf_d = asm_w;
                        if (last) begin
                            if (fetch_q) begin
                                if_done_d = 1'b1;
                                if_data_d = asm_w;
                            end else begin
                                mem_done_d = 1'b1;
                                if (!we_q)
                                    mem_rdata_d = asm_w;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if (adv) begin
                                ram_a_d    = ram_a_q + ADDR_W'(1);
                                ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                                ram_wr_d   = we_q;
                            end
                        end
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    // A stalled cycle must never strobe the RAM, and a redirect seen in
    // the done cycle of a fetch cancels the fetched word.
    assign ram_wr    = ram_wr_q & rdy;
    assign if_done   = if_done_q & ~jump_flag;
    assign mem_done  = mem_done_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model and a
// scoreboard of expected done pulses.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        jump_flag;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    typedef struct {
        bit          fetch;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;
    logic [7:0]  mem [0:65535];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .jump_flag(jump_flag),
        .ram_a(ram_a), .ram_wr(ram_wr),
        .ram_dout(ram_dout), .ram_din(ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, frozen together with the rest of the system by rdy.
    always @(posedge clk) begin
        if (rdy) begin
            if (ram_wr)
                mem[ram_a[15:0]] <= ram_dout;
            ram_din <= mem[ram_a[15:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit fetch, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = fetch ? if_done : mem_done;
        end
        check(fetch ? "if_done_timeout" : "mem_done_timeout",
              {31'b0, seen}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (if_done || mem_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {30'b0, if_done, mem_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_kind", {31'b0, if_done}, {31'b0, e.fetch});
                check("done_data", if_done ? if_data : mem_rdata, e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'h00;
        mem[16'h0100] = 8'h13;
        mem[16'h0300] = 8'h11;
        mem[16'h0301] = 8'h22;
        mem[16'h0302] = 8'h33;
        mem[16'h0303] = 8'h44;
        mem[16'hFFFE] = 8'hA1;
        mem[16'hFFFF] = 8'hB2;
        mem[16'h0000] = 8'hC3;
        mem[16'h0001] = 8'hD4;

        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
        mem_len = 2'd0; mem_wdata = '0; jump_flag = 1'b0;

        repeat (2) tick();
        check("rst_if_done", {31'b0, if_done}, 32'd0);
        check("rst_mem_done", {31'b0, mem_done}, 32'd0);
        check("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;

        // Fetch at 0x100: four byte addresses then if_done in cycle 5.
        if_req = 1'b1; if_addr = 32'h100;
        sb.push_back('{1'b1, 32'h0000_0013});
        tick();
        for (int k = 0; k < 4; k++) begin
            check("fetch_ram_a", ram_a, 32'h100 + k);
            check("fetch_ram_wr", {31'b0, ram_wr}, 32'd0);
            tick();
        end
        check("fetch_no_early_done", {31'b0, if_done}, 32'd0);
        tick();
        check("fetch_done_c5", {31'b0, if_done}, 32'd1);
        if_req = 1'b0;
        tick();

        // Half-word store.
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1;
        mem_addr = 32'h2000; mem_wdata = 32'hAABB_CCDD;
        sb.push_back('{1'b0, exp_rdata});
        tick();
        check("st_wr0", {31'b0, ram_wr}, 32'd1);
        check("st_a0", ram_a, 32'h2000);
        check("st_d0", {24'b0, ram_dout}, 32'hDD);
        tick();
        check("st_wr1", {31'b0, ram_wr}, 32'd1);
        check("st_a1", ram_a, 32'h2001);
        check("st_d1", {24'b0, ram_dout}, 32'hCC);
        tick();
        check("st_done_c2", {31'b0, mem_done}, 32'd1);
        check("st_wr_off", {31'b0, ram_wr}, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        check("st_wr_idle", {31'b0, ram_wr}, 32'd0);
        check("st_mem0", {24'b0, mem[16'h2000]}, 32'hDD);
        check("st_mem1", {24'b0, mem[16'h2001]}, 32'hCC);
        check("st_mem2", {24'b0, mem[16'h2002]}, 32'h00);

        // Simultaneous requests: the byte load wins, then the fetch.
        mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h100;
        exp_rdata = 32'h0000_0011;
        sb.push_back('{1'b0, exp_rdata});
        sb.push_back('{1'b1, 32'h0000_0013});
        tick();
        check("prio_ram_a", ram_a, 32'h300);
        tick();
        tick();
        check("prio_ld_done_c2", {31'b0, mem_done}, 32'd1);
        mem_req = 1'b0;
        tick();
        check("prio_no_grant_in_done", ram_a, 32'h300);
        tick();
        check("prio_fetch_start", ram_a, 32'h100);
        wait_done(1'b1, 8);
        if_req = 1'b0;
        tick();

        // Redirect in cycle 2 aborts the fetch; the new one is granted next.
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        tick();
        jump_flag = 1'b1; if_addr = 32'h300;
        tick();
        jump_flag = 1'b0;
        check("jmp_no_done", {31'b0, if_done}, 32'd0);
        sb.push_back('{1'b1, 32'h4433_2211});
        tick();
        check("jmp_regrant", ram_a, 32'h300);
        wait_done(1'b1, 8);
        if_req = 1'b0;
        tick();

        // Word load stalled for three cycles during cycle 1.
        mem_req = 1'b1; mem_len = 2'd2; mem_addr = 32'h300;
        exp_rdata = 32'h4433_2211;
        sb.push_back('{1'b0, exp_rdata});
        tick();
        tick();
        rdy = 1'b0;
        tick();
        check("stall_ram_a", ram_a, 32'h301);
        check("stall_no_done", {31'b0, mem_done}, 32'd0);
        tick();
        tick();
        rdy = 1'b1;
        tick();
        tick();
        tick();
        check("stall_done_not_c7", {31'b0, mem_done}, 32'd0);
        tick();
        check("stall_done_c8", {31'b0, mem_done}, 32'd1);
        mem_req = 1'b0;
        tick();

        // Reset during a word store after bytes 0 and 1.
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h2100; mem_wdata = 32'h0102_0304;
        tick();
        check("rst_st_d0", {24'b0, ram_dout}, 32'h04);
        tick();
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        tick();
        check("mid_rst_ram_wr", {31'b0, ram_wr}, 32'd0);
        check("mid_rst_ram_a", ram_a, 32'd0);
        check("mid_rst_ram_dout", {24'b0, ram_dout}, 32'd0);
        check("mid_rst_mem_rdata", mem_rdata, 32'd0);
        check("mid_rst_if_data", if_data, 32'd0);
        rst = 1'b0;
        exp_rdata = '0;
        tick();
        tick();
        check("mid_rst_b0", {24'b0, mem[16'h2100]}, 32'h04);
        check("mid_rst_b1", {24'b0, mem[16'h2101]}, 32'h03);
        check("mid_rst_b2", {24'b0, mem[16'h2102]}, 32'h00);
        check("mid_rst_b3", {24'b0, mem[16'h2103]}, 32'h00);
        check("mid_rst_no_done", {31'b0, mem_done}, 32'd0);

        // Size code 3 reads a word, wrapping past the top of memory.
        mem_req = 1'b1; mem_len = 2'd3; mem_addr = 32'hFFFF_FFFE;
        exp_rdata = 32'hD4C3_B2A1;
        sb.push_back('{1'b0, exp_rdata});
        tick();
        check("wrap_a0", ram_a, 32'hFFFF_FFFE);
        tick();
        tick();
        check("wrap_a2", ram_a, 32'h0000_0000);
        wait_done(1'b0, 6);
        mem_req = 1'b0;
        tick();

        // Half-word load under a standing redirect, zero-extended and held.
        jump_flag = 1'b1;
        mem_req = 1'b1; mem_len = 2'd1; mem_addr = 32'h302;
        exp_rdata = 32'h0000_4433;
        sb.push_back('{1'b0, exp_rdata});
        wait_done(1'b0, 8);
        mem_req = 1'b0; jump_flag = 1'b0;
        tick();
        tick();
        check("ld_hold", mem_rdata, 32'h0000_4433);

        // Redirect in the done cycle of a fetch suppresses if_done.
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        repeat (5) tick();
        jump_flag = 1'b1; if_req = 1'b0;
        #1;
        check("jmp_in_done", {31'b0, if_done}, 32'd0);
        tick();
        jump_flag = 1'b0;
        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
